// File: rtl/sd_boot_sched_if.sv
//------------------------------------------------------------------------------
// Module   : sd_boot_sched_if
// Purpose  : Block-read request/response bundle between the boot-load
//            scheduler (master) and the SD block-read engine (slave).
// Signals  : rd_req  - block read request (master -> slave)
//            rd_blk  - SD block number for rd_req
//            rd_dst  - memory byte address for the block
//            rd_ack  - engine accepted the request (slave -> master)
//            rd_done - one-cycle pulse: block written to memory
//            rd_err  - one-cycle pulse: block failed (CRC or timeout)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface sd_boot_sched_if #(
  parameter int NPHYS = 56
);
  logic             rd_req;
  logic [31:0]      rd_blk;
  logic [NPHYS-1:0] rd_dst;
  logic             rd_ack;
  logic             rd_done;
  logic             rd_err;

  modport master (
    output rd_req,
    output rd_blk,
    output rd_dst,
    input  rd_ack,
    input  rd_done,
    input  rd_err
  );

  modport slave (
    input  rd_req,
    input  rd_blk,
    input  rd_dst,
    output rd_ack,
    output rd_done,
    output rd_err
  );
endinterface

`default_nettype wire

// File: rtl/sd_boot_sched.sv
//------------------------------------------------------------------------------
// Module   : sd_boot_sched
// Purpose  : Boot-time block-load sequencer. Holds the CPU cluster in reset,
//            loads the channel 0 then channel 1 boot regions from the SD card
//            contiguously from LOAD_BASE, then releases the cluster reset
//            through a request/acknowledge handshake.
// Ports    : clk, reset        - core clock, synchronous active-high reset
//            boot_en           - boot-load strap, sampled once at latch
//            block_addr_0/1    - first SD block number per channel
//            block_count_0/1   - block count per channel (0 = skip)
//            sd                - block-read bundle (master modport)
//            reset_out         - CPU cluster reset request
//            reset_out_ack     - cluster reset state echo
//            busy, done, fail  - load in progress / finished / failed
// Config   : SD_BOOT_RETRY_EN  - when defined, each block is retried up to
//            MAX_RETRY times after rd_err; otherwise the first error fails.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sd_boot_sched #(
  parameter int               NPHYS     = 56,
  parameter int               BLK_LOG2  = 9,
  parameter logic [NPHYS-1:0] LOAD_BASE = '0,
  parameter int               MAX_RETRY = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   boot_en,
  input  logic [31:0]            block_addr_0,
  input  logic [31:0]            block_addr_1,
  input  logic [31:0]            block_count_0,
  input  logic [31:0]            block_count_1,
  sd_boot_sched_if.master        sd,
  output logic                   reset_out,
  input  logic                   reset_out_ack,
  output logic                   busy,
  output logic                   done,
  output logic                   fail
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEL     = 3'd1,
    S_REQ     = 3'd2,
    S_WAIT    = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5,
    S_FAIL    = 3'd6
  } state_t;

  localparam logic [NPHYS-1:0] c_BLK_BYTES = {{(NPHYS-1){1'b0}}, 1'b1} << BLK_LOG2;

`ifdef SD_BOOT_RETRY_EN
  localparam int                   c_RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [c_RETRY_W-1:0] c_MAX_RETRY = c_RETRY_W'(MAX_RETRY);
  logic [c_RETRY_W-1:0] r_retry;
`endif

  state_t      r_state;
  logic        r_chan;        // channel currently being loaded
  logic [31:0] r_addr0;
  logic [31:0] r_addr1;
  logic [31:0] r_cnt0;        // blocks still to load per channel
  logic [31:0] r_cnt1;
  logic [31:0] w_cur_cnt;

  assign w_cur_cnt = r_chan ? r_cnt1 : r_cnt0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_chan    <= 1'b0;
      r_addr0   <= '0;
      r_addr1   <= '0;
      r_cnt0    <= '0;
      r_cnt1    <= '0;
      sd.rd_req <= 1'b0;
      sd.rd_blk <= '0;
      sd.rd_dst <= LOAD_BASE;
      reset_out <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
`ifdef SD_BOOT_RETRY_EN
      r_retry   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // A cleared strap loads nothing but still runs the release sequence.
          r_addr0 <= block_addr_0;
          r_addr1 <= block_addr_1;
          r_cnt0  <= boot_en ? block_count_0 : 32'd0;
          r_cnt1  <= boot_en ? block_count_1 : 32'd0;
          busy    <= 1'b1;
          r_state <= S_SEL;
        end

        S_SEL: begin
          // rd_dst is deliberately not reloaded: channel 1 lands right after
          // channel 0's last block.
          if (r_cnt0 != 32'd0) begin
            r_chan    <= 1'b0;
            sd.rd_blk <= r_addr0;
            sd.rd_req <= 1'b1;
            r_state   <= S_REQ;
          end else if (r_cnt1 != 32'd0) begin
            r_chan    <= 1'b1;
            sd.rd_blk <= r_addr1;
            sd.rd_req <= 1'b1;
            r_state   <= S_REQ;
          end else begin
            busy    <= 1'b0;
            r_state <= S_RELEASE;
          end
        end

        S_REQ: begin
          // rd_blk/rd_dst are only written outside REQ, so they hold here.
          if (sd.rd_ack) begin
            sd.rd_req <= 1'b0;
            r_state   <= S_WAIT;
          end
        end

        S_WAIT: begin
          // Error is tested first so a simultaneous done/err takes the error.
          if (sd.rd_err) begin
`ifdef SD_BOOT_RETRY_EN
            if (r_retry < c_MAX_RETRY) begin
              r_retry   <= r_retry + 1'b1;
              sd.rd_req <= 1'b1;
              r_state   <= S_REQ;
            end else begin
              busy    <= 1'b0;
              fail    <= 1'b1;
              r_state <= S_FAIL;
            end
`else
            busy    <= 1'b0;
            fail    <= 1'b1;
            r_state <= S_FAIL;
`endif
          end else if (sd.rd_done) begin
`ifdef SD_BOOT_RETRY_EN
            r_retry   <= '0;
`endif
            sd.rd_blk <= sd.rd_blk + 32'd1;
            sd.rd_dst <= sd.rd_dst + c_BLK_BYTES;
            if (r_chan) begin
              r_cnt1 <= r_cnt1 - 32'd1;
            end else begin
              r_cnt0 <= r_cnt0 - 32'd1;
            end
            if (w_cur_cnt != 32'd1) begin
              sd.rd_req <= 1'b1;
              r_state   <= S_REQ;
            end else begin
              r_state <= S_SEL;
            end
          end
        end

        S_RELEASE: begin
          reset_out <= 1'b0;
          // Only trust the echo once our own request has actually dropped.
          if (!reset_out && !reset_out_ack) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_state <= S_DONE;
        end

        S_FAIL: begin
          r_state <= S_FAIL;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sd_boot_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_sd_boot_sched
// Purpose  : Self-checking bench for sd_boot_sched. An SD engine model answers
//            block requests; expected {block, destination} pairs are queued
//            per test and popped as each request is accepted. Retry tests
//            follow the SD_BOOT_RETRY_EN build option.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sd_boot_sched;

  localparam int NPHYS   = 56;
  localparam int PL_DONE = 0;
  localparam int PL_ERR  = 1;
  localparam int PL_BOTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        boot_en = 1'b0;
  logic [31:0] block_addr_0 = '0;
  logic [31:0] block_addr_1 = '0;
  logic [31:0] block_count_0 = '0;
  logic [31:0] block_count_1 = '0;
  logic        reset_out;
  logic        reset_out_ack;
  logic        busy;
  logic        done;
  logic        fail;

  sd_boot_sched_if #(.NPHYS(NPHYS)) bus ();

  sd_boot_sched #(
    .NPHYS     (NPHYS),
    .BLK_LOG2  (9),
    .LOAD_BASE ({NPHYS{1'b0}}),
    .MAX_RETRY (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .boot_en       (boot_en),
    .block_addr_0  (block_addr_0),
    .block_addr_1  (block_addr_1),
    .block_count_0 (block_count_0),
    .block_count_1 (block_count_1),
    .sd            (bus),
    .reset_out     (reset_out),
    .reset_out_ack (reset_out_ack),
    .busy          (busy),
    .done          (done),
    .fail          (fail)
  );

  always #5 clk = ~clk;

  logic [87:0] exp_q[$];   // {blk[31:0], dst[55:0]}
  int          plan_q[$];  // engine response per accepted request
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] blk, input logic [NPHYS-1:0] dst);
    exp_q.push_back({blk, dst});
  endtask

  // Cluster reset echo: follows reset_out with one cycle of lag.
  initial begin
    reset_out_ack = 1'b1;
    forever begin
      @(negedge clk);
      reset_out_ack = reset_out;
    end
  end

  task automatic do_reset(input logic en, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] c0, input logic [31:0] c1);
    @(negedge clk);
    reset       = 1'b1;
    bus.rd_ack  = 1'b0;
    bus.rd_done = 1'b0;
    bus.rd_err  = 1'b0;
    boot_en       = en;
    block_addr_0  = a0;
    block_addr_1  = a1;
    block_count_0 = c0;
    block_count_1 = c1;
    exp_q.delete();
    plan_q.delete();
    repeat (2) @(negedge clk);
    chk("rst_rd_req", bus.rd_req, 0);
    chk("rst_rd_blk", bus.rd_blk, 0);
    chk("rst_rd_dst", bus.rd_dst, 0);
    chk("rst_reset_out", reset_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    reset = 1'b0;
  endtask

  // Engine model: accepts each request after ack_dly cycles (with a stray
  // rd_done pulse during long delays), then responds done_dly cycles later.
  task automatic serve(input int ack_dly, input int done_dly, input int stop_after, input int budget);
    int               cyc;
    int               acc;
    int               unstable;
    int               pl;
    logic [31:0]      b0;
    logic [NPHYS-1:0] d0;
    logic [87:0]      e;
    cyc = 0;
    acc = 0;
    while (!(done || fail) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.rd_req) begin
        b0 = bus.rd_blk;
        d0 = bus.rd_dst;
        unstable = 0;
        for (int k = 0; k < ack_dly; k++) begin
          if (k == 3) bus.rd_done = 1'b1;
          @(negedge clk);
          cyc++;
          bus.rd_done = 1'b0;
          if (!bus.rd_req || bus.rd_blk !== b0 || bus.rd_dst !== d0) unstable++;
        end
        chk("req_stable", unstable, 0);
        bus.rd_ack = 1'b1;
        @(negedge clk);
        cyc++;
        bus.rd_ack = 1'b0;
        chk("req_drop", bus.rd_req, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("req_blk", b0, e[87:56]);
          chk("req_dst", d0, e[55:0]);
        end
        acc++;
        if (stop_after > 0 && acc == stop_after) return;
        for (int k = 1; k < done_dly; k++) begin
          @(negedge clk);
          cyc++;
        end
        pl = (plan_q.size() > 0) ? plan_q.pop_front() : PL_DONE;
        bus.rd_done = (pl != PL_ERR);
        bus.rd_err  = (pl != PL_DONE);
        @(negedge clk);
        cyc++;
        bus.rd_done = 1'b0;
        bus.rd_err  = 1'b0;
      end
    end
    if (!(done || fail)) chk("serve_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rd_ack  = 1'b0;
    bus.rd_done = 1'b0;
    bus.rd_err  = 1'b0;

    // Two blocks on channel 0, immediate ack; check request start timing.
    do_reset(1'b1, 32'h10, 32'h0, 32'd2, 32'd0);
    push_exp(32'h10, 56'h0);
    push_exp(32'h11, 56'h200);
    @(negedge clk);
    chk("t1_req_after_latch", bus.rd_req, 0);
    chk("t1_busy_after_latch", busy, 1);
    @(negedge clk);
    chk("t1_req_after_sel", bus.rd_req, 1);
    chk("t1_blk_after_sel", bus.rd_blk, 32'h10);
    serve(0, 5, 0, 300);
    chk("t1_done", done, 1);
    chk("t1_reset_out", reset_out, 0);
    chk("t1_fail", fail, 0);
    chk("t1_q_empty", exp_q.size(), 0);

    // Channel 0 first, then channel 1 continues contiguously.
    do_reset(1'b1, 32'h100, 32'h800, 32'd1, 32'd3);
    push_exp(32'h100, 56'h0);
    push_exp(32'h800, 56'h200);
    push_exp(32'h801, 56'h400);
    push_exp(32'h802, 56'h600);
    serve(0, 3, 0, 400);
    chk("t2_done", done, 1);
    chk("t2_busy", busy, 0);
    chk("t2_q_empty", exp_q.size(), 0);

    // Strap off: nothing loaded, release 2 cycles after latch.
    do_reset(1'b0, 32'h100, 32'h200, 32'd5, 32'd5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_no_req", bus.rd_req, 0);
      chk("t3_reset_out", reset_out, (i < 2) ? 1 : 0);
      chk("t3_done", done, (i == 3) ? 1 : 0);
    end

`ifdef SD_BOOT_RETRY_EN
    // Two errors then success on block 0x10, then channel 1.
    do_reset(1'b1, 32'h10, 32'h30, 32'd1, 32'd1);
    plan_q = '{PL_ERR, PL_ERR, PL_DONE, PL_DONE};
    push_exp(32'h10, 56'h0);
    push_exp(32'h10, 56'h0);
    push_exp(32'h10, 56'h0);
    push_exp(32'h30, 56'h200);
    serve(0, 2, 0, 400);
    chk("t4_done", done, 1);
    chk("t4_fail", fail, 0);
    chk("t4_q_empty", exp_q.size(), 0);

    // Four errors exhaust the retries.
    do_reset(1'b1, 32'h10, 32'h0, 32'd1, 32'd0);
    plan_q = '{PL_ERR, PL_ERR, PL_ERR, PL_ERR};
    repeat (4) push_exp(32'h10, 56'h0);
    serve(0, 2, 0, 400);
`else
    // Without retry the first error fails the load.
    do_reset(1'b1, 32'h10, 32'h0, 32'd1, 32'd0);
    plan_q = '{PL_ERR};
    push_exp(32'h10, 56'h0);
    serve(0, 2, 0, 400);
`endif
    repeat (3) @(negedge clk);
    chk("t5_fail", fail, 1);
    chk("t5_done", done, 0);
    chk("t5_reset_out", reset_out, 1);
    chk("t5_busy", busy, 0);
    chk("t5_q_empty", exp_q.size(), 0);

    // Slow ack with a stray done in REQ; done+err together takes the error.
    do_reset(1'b1, 32'h20, 32'h0, 32'd1, 32'd0);
    plan_q = '{PL_BOTH};
    push_exp(32'h20, 56'h0);
`ifdef SD_BOOT_RETRY_EN
    push_exp(32'h20, 56'h0);
`endif
    serve(7, 2, 0, 400);
`ifdef SD_BOOT_RETRY_EN
    chk("t6_done", done, 1);
    chk("t6_fail", fail, 0);
`else
    chk("t6_done", done, 0);
    chk("t6_fail", fail, 1);
`endif
    chk("t6_q_empty", exp_q.size(), 0);

    // Reset while waiting on block 3 of 4, then a full restart.
    do_reset(1'b1, 32'h40, 32'h0, 32'd4, 32'd0);
    push_exp(32'h40, 56'h0);
    push_exp(32'h41, 56'h200);
    push_exp(32'h42, 56'h400);
    serve(0, 3, 3, 400);
    chk("t7_busy_mid", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t7_rst_req", bus.rd_req, 0);
    chk("t7_rst_reset_out", reset_out, 1);
    chk("t7_rst_busy", busy, 0);
    do_reset(1'b1, 32'h40, 32'h0, 32'd4, 32'd0);
    push_exp(32'h40, 56'h0);
    push_exp(32'h41, 56'h200);
    push_exp(32'h42, 56'h400);
    push_exp(32'h43, 56'h600);
    serve(0, 3, 0, 400);
    chk("t7_done", done, 1);
    chk("t7_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
